// File: rtl/cpu_divider.sv
// cpu_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock, sign fix-up in a final cycle, and a one-cycle valid pulse.
// Accept-to-valid latency is 33 edges.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op[1:0]      request; op is funct3[1:0] (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   src_a, src_b        dividend, divisor
//   busy                operation in flight (RUN or FIX), decoded from state
//   valid               one-cycle pulse when result is updated
//   result              quotient or remainder, held until the next completion
// Optional build macro: CPU_DIV_EARLY_OUT_EN. When it is defined, divide-by-zero and
// signed overflow skip RUN and go straight to FIX with the answer preloaded.
module cpu_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state, state_next;
    logic [1:0]      op_q;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] dvd;        // dividend, shifted out as quotient bits shift in
    logic [XLEN-1:0] rem;        // partial remainder
    logic [CW-1:0]   cnt;
    logic            q_neg, r_neg, div_zero;

    logic            accept, special;
    logic            signed_in, div_zero_in;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] quo_fix, rem_fix;

    // Operand conditioning at accept
    assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
    assign signed_in   = ~op[0];
    assign div_zero_in = (src_b == '0);
    assign a_abs       = (signed_in && src_a[XLEN-1]) ? XLEN'(-src_a) : src_a;
    assign b_abs       = (signed_in && src_b[XLEN-1]) ? XLEN'(-src_b) : src_b;

`ifdef CPU_DIV_EARLY_OUT_EN
    logic ovf_in;
    assign ovf_in  = signed_in && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    assign special = div_zero_in || ovf_in;
`else
    assign special = 1'b0;
`endif

    // One restoring step: shift in next dividend bit, trial-subtract 33 bits wide
    assign rem_sh = {rem, dvd[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    // Sign correction; a zero divisor keeps the all-ones quotient un-negated
    assign quo_fix = (q_neg && ~op_q[0] && ~div_zero) ? XLEN'(-dvd) : dvd;
    assign rem_fix = (r_neg && ~op_q[0]) ? XLEN'(-rem) : rem;

    assign busy = (state == S_RUN) || (state == S_FIX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = special ? S_FIX : S_RUN;
            S_RUN:   if (cnt == CW'(31)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = accept ? (special ? S_FIX : S_RUN) : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            divisor  <= '0;
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            valid    <= 1'b0;
            result   <= '0;
        end else begin
            valid <= (state == S_FIX);
            if (accept) begin
                op_q     <= op;
                divisor  <= b_abs;
                dvd      <= a_abs;
                rem      <= '0;
                cnt      <= '0;
                q_neg    <= signed_in & (src_a[XLEN-1] ^ src_b[XLEN-1]);
                r_neg    <= signed_in & src_a[XLEN-1];
                div_zero <= div_zero_in;
`ifdef CPU_DIV_EARLY_OUT_EN
                // Preload the architectural answer; FIX then applies no sign change
                if (special) begin
                    dvd   <= div_zero_in ? '1 : {1'b1, {(XLEN-1){1'b0}}};
                    rem   <= div_zero_in ? src_a : '0;
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end
`endif
            end else if (state == S_RUN) begin
                rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                dvd <= {dvd[XLEN-2:0], ~diff[XLEN]};
                cnt <= cnt + CW'(1);
            end else if (state == S_FIX) begin
                result <= op_q[1] ? rem_fix : quo_fix;
            end
        end
    end

endmodule
